uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_tx_periph_if.sv | 24 ++
 rtl/uart_tx_periph.sv | 154 +++++++++++++++
 tb/tb_uart_tx_periph.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_periph_if.sv
// rtl/uart_tx_periph_if.sv - CPU bus bundle for the UART transmit peripheral
interface uart_tx_periph_if;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;

    modport master (
        output bus_address,
        output bus_write_data,
        output bus_write_enable,
        output bus_read_enable,
        input  bus_read_data
    );

    modport slave (
        input  bus_address,
        input  bus_write_data,
        input  bus_write_enable,
        input  bus_read_enable,
        output bus_read_data
    );
endinterface

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - bus-mapped 8N1 UART transmitter with a TX FIFO
module uart_tx_periph #(
    parameter logic [63:0] BASE_ADDR    = 64'h8000_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_periph_if.slave  bus,
    output logic             uart_tx,
    output logic             tx_busy
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [63:0] STATUS_ADDR = BASE_ADDR + 64'd8;
    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [8:0]  DEPTH_CNT   = 9'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    count;
    logic          overflow;

    logic          wr_data;
    logic          rd_status;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          baud_end;
    logic [63:0]   status_word;
    logic          unused_write_bits;

    assign unused_write_bits = ^bus.bus_write_data[63:8];

    assign wr_data    = bus.bus_write_enable && (bus.bus_address == BASE_ADDR);
    assign rd_status  = bus.bus_read_enable && (bus.bus_address == STATUS_ADDR);
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == 9'd0);
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign push       = wr_data && !fifo_full;
    // The head is consumed either from idle or at the last STOP cycle, so queued frames abut.
    assign pop        = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud_end));
    assign tx_busy    = (state != ST_IDLE);

    assign status_word = {47'd0, count, 4'd0, overflow, fifo_empty, fifo_full, tx_busy};

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= bus.bus_write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= 9'd0;
            overflow          <= 1'b0;
            bus.bus_read_data <= 64'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {8'd0, push} - {8'd0, pop};

            // A fresh overflow in the same cycle as a STATUS read keeps the flag set.
            if (wr_data && fifo_full) begin
                overflow <= 1'b1;
            end else if (rd_status) begin
                overflow <= 1'b0;
            end

            if (bus.bus_read_enable) begin
                bus.bus_read_data <= rd_status ? status_word : 64'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= 16'd0;
                        state    <= ST_START;
                        uart_tx  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd0;
                        state    <= ST_DATA;
                        uart_tx  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            state   <= ST_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            state   <= ST_START;
                            uart_tx <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - self-checking bench for uart_tx_periph against a frame-timeline model
module tb_uart_tx_periph;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 16;
    localparam int          FRAME = 10 * CPB;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    logic uart_tx;
    logic tx_busy;

    uart_tx_periph_if bus ();

    uart_tx_periph #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    // Each accepted byte is a frame occupying edges [start, stop) on the line.
    typedef struct {
        int         w;
        int         start;
        int         stop;
        logic [7:0] d;
    } frame_t;

    frame_t      frames[$];
    int          now       = 0;
    int          line_free = 0;
    int          checks    = 0;
    int          errors    = 0;
    logic        ovf_m     = 1'b0;
    logic [63:0] rd_hold   = 64'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, now);
        end
    endtask

    function automatic int active_idx(input int t);
        for (int i = 0; i < frames.size(); i++) begin
            if (t >= frames[i].start && t < frames[i].stop) return i;
        end
        return -1;
    endfunction

    function automatic logic exp_line(input int t);
        int i;
        int pos;
        i = active_idx(t);
        if (i < 0) return 1'b1;
        pos = (t - frames[i].start) / CPB;
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return frames[i].d[pos - 1];
    endfunction

    function automatic int fifo_count(input int k);
        int n;
        n = 0;
        for (int i = 0; i < frames.size(); i++) begin
            if (frames[i].stop > frames[i].start && frames[i].w < k && frames[i].start >= k) n++;
        end
        return n;
    endfunction

    task automatic model_edge(input int k, input bit rst, input bit we, input bit re,
                              input logic [63:0] addr, input logic [63:0] wdata);
        int     cnt;
        int     st;
        logic   busy;
        bit     new_ovf;
        frame_t f;
        if (rst) begin
            for (int i = 0; i < frames.size(); i++) begin
                if (frames[i].start >= k) frames[i].stop = frames[i].start;
                else if (frames[i].stop > k) frames[i].stop = k;
            end
            line_free = k;
            ovf_m     = 1'b0;
            rd_hold   = 64'd0;
            return;
        end
        cnt  = fifo_count(k);
        busy = (active_idx(k - 1) >= 0);
        if (re) begin
            if (addr == BASE + 64'd8)
                rd_hold = {47'd0, 9'(cnt), 4'd0, ovf_m, (cnt == 0), (cnt == DEPTH), busy};
            else
                rd_hold = 64'd0;
        end
        new_ovf = 1'b0;
        if (we && addr == BASE) begin
            if (cnt >= DEPTH) begin
                new_ovf = 1'b1;
            end else begin
                st      = (k + 1 > line_free) ? k + 1 : line_free;
                f.w     = k;
                f.start = st;
                f.stop  = st + FRAME;
                f.d     = wdata[7:0];
                frames.push_back(f);
                line_free = st + FRAME;
            end
        end
        if (new_ovf) ovf_m = 1'b1;
        else if (re && addr == BASE + 64'd8) ovf_m = 1'b0;
    endtask

    task automatic step(input bit rst, input bit we, input bit re,
                        input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        if (now > 0) begin
            check("uart_tx", 64'(uart_tx), 64'(exp_line(now)));
            check("tx_busy", 64'(tx_busy), 64'(active_idx(now) >= 0));
            check("read_data", bus.bus_read_data, rd_hold);
        end
        reset                = rst;
        bus.bus_write_enable = we;
        bus.bus_read_enable  = re;
        bus.bus_address      = addr;
        bus.bus_write_data   = wdata;
        model_edge(now + 1, rst, we, re, addr, wdata);
        @(posedge clk);
        now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic wr(input logic [63:0] addr, input logic [7:0] d);
        step(1'b0, 1'b1, 1'b0, addr, {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FF00 | 64'(d));
    endtask

    task automatic rd(input logic [63:0] addr);
        step(1'b0, 1'b0, 1'b1, addr, 64'd0);
    endtask

    initial begin
        reset                = 1'b1;
        bus.bus_write_enable = 1'b0;
        bus.bus_read_enable  = 1'b0;
        bus.bus_address      = 64'd0;
        bus.bus_write_data   = 64'd0;

        step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        step(1'b1, 1'b1, 1'b1, BASE, 64'h77);
        step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        #1 check("reset_tx", 64'(uart_tx), 64'd1);
        check("reset_busy", 64'(tx_busy), 64'd0);
        check("reset_rdata", bus.bus_read_data, 64'd0);

        rd(BASE + 64'd8);
        #1 check("status_idle", bus.bus_read_data, 64'h4);
        wr(BASE + 64'h10, 8'h99);
        rd(BASE + 64'd8);
        #1 check("status_bad_addr_write", bus.bus_read_data, 64'h4);
        rd(BASE);
        idle(2);

        wr(BASE, 8'h41);
        idle(45);
        wr(BASE, 8'h55);
        wr(BASE, 8'hAA);
        idle(85);

        wr(BASE, 8'h11);
        idle(3);
        for (int i = 0; i < 17; i++) wr(BASE, 8'($urandom));
        rd(BASE + 64'd8);
        #1 check("overflow_set", 64'(bus.bus_read_data[3]), 64'd1);
        check("fifo_full", 64'(bus.bus_read_data[16:8]), 64'd16);
        idle(2);
        rd(BASE + 64'd8);
        #1 check("overflow_cleared", 64'(bus.bus_read_data[3]), 64'd0);
        idle(720);

        for (int i = 0; i < 6; i++) wr(BASE, 8'($urandom));
        idle(14);
        step(1'b1, 1'b1, 1'b0, BASE, 64'h3C);
        #1 check("abort_tx", 64'(uart_tx), 64'd1);
        rd(BASE + 64'd8);
        #1 check("status_after_abort", bus.bus_read_data, 64'h4);
        idle(300);

        for (int i = 0; i < 1500; i++) begin
            int          r;
            int          sel;
            logic [63:0] a;
            r   = $urandom_range(0, 499);
            sel = $urandom_range(0, 3);
            a   = (sel < 2) ? BASE : (sel == 2) ? BASE + 64'd8 : BASE + 64'h10;
            if (r == 0)
                step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
            else
                step(1'b0, ($urandom_range(0, 99) < 22), ($urandom_range(0, 99) < 15),
                     a, {$urandom, $urandom});
        end
        idle(700);
        rd(BASE + 64'd8);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
